// File: rtl/video_to_stream.sv
// video_to_stream: turns raster-timed RGB video (vs/de + 8-bit R/G/B) into a
// ready/valid pixel stream. Pixels are buffered in a FIFO because the raster
// source cannot stall. Each beat is tagged with start-of-frame and end-of-line.
// Overflow and frame geometry are reported through sticky flags.
module video_to_stream #(
  parameter int   FIFO_DEPTH = 2048,
  parameter int   H_DISP     = 1920,
  parameter int   V_DISP     = 1080,
  parameter logic VS_POL     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vid_vs,
  input  logic                          vid_de,
  input  logic [7:0]                    vid_r,
  input  logic [7:0]                    vid_g,
  input  logic [7:0]                    vid_b,
  output logic [23:0]                   m_data,
  output logic                          m_sof,
  output logic                          m_eol,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          size_err,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DROP} state_t;

  state_t          state;
  logic            vs_d;
  logic            vs_rise;
  logic            capture;

  // One-pixel hold register: a pixel can only be tagged eol once we see
  // whether the following cycle still has de high.
  logic [23:0]     p_data;
  logic            p_sof;
  logic            p_vld;

  logic [25:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            full;
  logic            rd_en;
  logic            wr_req;
  logic            wr_en;
  logic            drop;
  logic [25:0]     wr_entry;
  logic [25:0]     head;

  logic [15:0]     px_cnt;
  logic [15:0]     ln_cnt;
  logic            eol_wr;
  logic            px_bad;
  logic            ln_bad;
  logic            size_set;

  assign vs_rise = (vs_d != VS_POL) && (vid_vs == VS_POL);
  assign capture = vid_de && ((state == WAIT_SOF) || (state == ACTIVE));
  assign full    = (level == LW'(FIFO_DEPTH));
  assign m_valid = (level != '0);
  assign rd_en   = m_valid && m_ready;
  assign head    = mem[rd_ptr];

  assign m_data     = m_valid ? head[23:0] : 24'd0;
  assign m_sof      = m_valid && head[25];
  assign m_eol      = m_valid && head[24];
  assign fifo_level = level;

  // Decide whether the held pixel leaves this cycle, and with which eol tag.
  // A vsync edge flushes a dangling pixel so a malformed line still ends.
  always_comb begin
    wr_req   = 1'b0;
    wr_entry = {p_sof, 1'b1, p_data};
    if (vs_rise) begin
      wr_req = p_vld;
    end else if (capture) begin
      wr_req   = p_vld;
      wr_entry = {p_sof, 1'b0, p_data};
    end else if (!vid_de && p_vld) begin
      wr_req = 1'b1;
    end
  end

  // A write into a full FIFO is refused even when a read frees a slot in the
  // same cycle; the refused pixel is dropped.
  assign wr_en = wr_req && !full;
  assign drop  = wr_req && full;

  // Geometry: line length is checked on every eol write, line count on the
  // vsync edge that closes a frame that was fully accepted.
  assign eol_wr   = wr_en && wr_entry[24];
  assign px_bad   = eol_wr && ((32'(px_cnt) + 32'd1) != 32'(H_DISP));
  assign ln_bad   = vs_rise && (state == ACTIVE) && (32'(ln_cnt) != 32'(V_DISP));
  assign size_set = px_bad || ln_bad;

  // FIFO storage array; not reset, the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame-tracking FSM and the capture hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vs_d   <= 1'b0;
      p_data <= 24'd0;
      p_sof  <= 1'b0;
      p_vld  <= 1'b0;
    end else begin
      vs_d <= vid_vs;
      if (vs_rise) begin
        state <= WAIT_SOF;
        p_vld <= 1'b0;
      end else begin
        case (state)
          WAIT_SOF, ACTIVE: begin
            if (drop) begin
              state <= DROP;
              p_vld <= 1'b0;
            end else if (vid_de) begin
              p_data <= {vid_r, vid_g, vid_b};
              p_sof  <= (state == WAIT_SOF);
              p_vld  <= 1'b1;
              state  <= ACTIVE;
            end else begin
              p_vld <= 1'b0;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  // Pixel-in-line and line-in-frame counters, saturating so a runaway input
  // cannot wrap back onto a legal size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_cnt <= 16'd0;
      ln_cnt <= 16'd0;
    end else if (vs_rise) begin
      px_cnt <= 16'd0;
      ln_cnt <= 16'd0;
    end else if (wr_en) begin
      if (wr_entry[24]) begin
        px_cnt <= 16'd0;
        if (ln_cnt != 16'hFFFF) ln_cnt <= ln_cnt + 16'd1;
      end else if (px_cnt != 16'hFFFF) begin
        px_cnt <= px_cnt + 16'd1;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      size_err <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (size_set)     size_err <= 1'b1;
      else if (clr_err) size_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_to_stream.sv
// Testbench for video_to_stream. Two instances share the video input:
// dut_a (FIFO_DEPTH=16) covers reset, framing, overflow and geometry;
// dut_b (FIFO_DEPTH=64) covers random back-pressure with a scoreboard.
module tb_video_to_stream;

  logic        clk;
  logic        rst_n;
  logic        vid_vs;
  logic        vid_de;
  logic [7:0]  vid_r;
  logic [7:0]  vid_g;
  logic [7:0]  vid_b;
  logic        clr_err;

  logic [23:0] m_data_a;
  logic        m_sof_a;
  logic        m_eol_a;
  logic        m_valid_a;
  logic        m_ready_a;
  logic [4:0]  fifo_level_a;
  logic        overflow_a;
  logic        size_err_a;

  logic [23:0] m_data_b;
  logic        m_sof_b;
  logic        m_eol_b;
  logic        m_valid_b;
  logic        m_ready_b;
  logic [6:0]  fifo_level_b;
  logic        overflow_b;
  logic        size_err_b;

  int          n_checks;
  int          n_fail;
  int          fid;
  logic        rand_en;
  logic        stab_en;
  logic        stall_b;
  logic [25:0] held_b;
  logic [25:0] qa[$];
  logic [25:0] qb[$];

  video_to_stream #(.FIFO_DEPTH(16), .H_DISP(8), .V_DISP(4), .VS_POL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .m_data(m_data_a), .m_sof(m_sof_a), .m_eol(m_eol_a), .m_valid(m_valid_a),
    .m_ready(m_ready_a), .fifo_level(fifo_level_a), .overflow(overflow_a),
    .size_err(size_err_a), .clr_err(clr_err)
  );

  video_to_stream #(.FIFO_DEPTH(64), .H_DISP(8), .V_DISP(4), .VS_POL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .vid_vs(vid_vs), .vid_de(vid_de),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .m_data(m_data_b), .m_sof(m_sof_b), .m_eol(m_eol_b), .m_valid(m_valid_b),
    .m_ready(m_ready_b), .fifo_level(fifo_level_b), .overflow(overflow_b),
    .size_err(size_err_b), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect accepted beats of dut_a, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && m_valid_a && m_ready_a) qa.push_back({m_sof_a, m_eol_a, m_data_a});
  end

  // Collect dut_b beats and check that a stalled head stays put.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stab_en && stall_b) begin
        n_checks++;
        if (!m_valid_b || ({m_sof_b, m_eol_b, m_data_b} !== held_b)) begin
          n_fail++;
          $display("[TB] FAIL hold_stable: got valid=%0b beat=%h expected valid=1 beat=%h",
                   m_valid_b, {m_sof_b, m_eol_b, m_data_b}, held_b);
        end
      end
      if (m_valid_b && m_ready_b) qb.push_back({m_sof_b, m_eol_b, m_data_b});
      stall_b = m_valid_b && !m_ready_b;
      held_b  = {m_sof_b, m_eol_b, m_data_b};
    end else begin
      stall_b = 1'b0;
    end
  end

  function automatic logic [23:0] pix(input int f, input int ln, input int px);
    return {8'(f), 8'(ln), 8'(px)};
  endfunction

  // Expected beat i of an 8x4 frame numbered f.
  function automatic logic [25:0] exp_beat(input int f, input int i);
    return {(i == 0), ((i % 8) == 7), pix(f, i / 8, i % 8)};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
    if (rand_en) m_ready_b = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    vid_de = 1'b0;
    {vid_r, vid_g, vid_b} = 24'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic gen_vs();
    fid++;
    vid_de = 1'b0;
    vid_vs = 1'b1;
    step();
    step();
    vid_vs = 1'b0;
    step();
    step();
  endtask

  task automatic gen_line(input int ln, input int npx, input int hb);
    for (int px = 0; px < npx; px++) begin
      vid_de = 1'b1;
      {vid_r, vid_g, vid_b} = pix(fid, ln, px);
      step();
    end
    idle(hb);
  endtask

  task automatic gen_frame();
    gen_vs();
    for (int ln = 0; ln < 4; ln++) gen_line(ln, 8, 4);
    idle(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_checks += 7;
    if (m_valid_a !== 1'b0)     begin n_fail++; $display("[TB] FAIL rst_valid: got %0b expected 0", m_valid_a); end
    if (m_data_a !== 24'd0)     begin n_fail++; $display("[TB] FAIL rst_data: got %h expected 0", m_data_a); end
    if (m_sof_a !== 1'b0)       begin n_fail++; $display("[TB] FAIL rst_sof: got %0b expected 0", m_sof_a); end
    if (m_eol_a !== 1'b0)       begin n_fail++; $display("[TB] FAIL rst_eol: got %0b expected 0", m_eol_a); end
    if (fifo_level_a !== 5'd0)  begin n_fail++; $display("[TB] FAIL rst_level: got %0d expected 0", fifo_level_a); end
    if (overflow_a !== 1'b0)    begin n_fail++; $display("[TB] FAIL rst_overflow: got %0b expected 0", overflow_a); end
    if (size_err_a !== 1'b0)    begin n_fail++; $display("[TB] FAIL rst_size_err: got %0b expected 0", size_err_a); end
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_midframe_release();
    qa.delete();
    gen_line(1, 8, 4);
    gen_line(2, 8, 4);
    n_checks += 2;
    if (qa.size() !== 0)       begin n_fail++; $display("[TB] FAIL mid_no_beats: got %0d expected 0", qa.size()); end
    if (fifo_level_a !== 5'd0) begin n_fail++; $display("[TB] FAIL mid_level: got %0d expected 0", fifo_level_a); end
  endtask

  task automatic test_full_frame();
    qa.delete();
    gen_frame();
    n_checks++;
    if (qa.size() !== 32) begin n_fail++; $display("[TB] FAIL frame_count: got %0d expected 32", qa.size()); end
    for (int i = 0; i < 32 && i < qa.size(); i++) begin
      n_checks++;
      if (qa[i] !== exp_beat(fid, i)) begin
        n_fail++;
        $display("[TB] FAIL frame_beat%0d: got %h expected %h", i, qa[i], exp_beat(fid, i));
      end
    end
    n_checks += 2;
    if (overflow_a !== 1'b0) begin n_fail++; $display("[TB] FAIL frame_overflow: got %0b expected 0", overflow_a); end
    if (size_err_a !== 1'b0) begin n_fail++; $display("[TB] FAIL frame_size_err: got %0b expected 0", size_err_a); end
  endtask

  task automatic test_overflow();
    int f;
    m_ready_a = 1'b0;
    qa.delete();
    gen_vs();
    f = fid;
    gen_line(0, 8, 4);
    gen_line(1, 8, 4);
    n_checks += 2;
    if (fifo_level_a !== 5'd16) begin n_fail++; $display("[TB] FAIL ovf_full_level: got %0d expected 16", fifo_level_a); end
    if (overflow_a !== 1'b0)    begin n_fail++; $display("[TB] FAIL ovf_early: got %0b expected 0", overflow_a); end
    gen_line(2, 8, 4);
    gen_line(3, 8, 4);
    n_checks += 2;
    if (overflow_a !== 1'b1)    begin n_fail++; $display("[TB] FAIL ovf_set: got %0b expected 1", overflow_a); end
    if (fifo_level_a !== 5'd16) begin n_fail++; $display("[TB] FAIL ovf_sat_level: got %0d expected 16", fifo_level_a); end
    m_ready_a = 1'b1;
    idle(24);
    n_checks++;
    if (qa.size() !== 16) begin n_fail++; $display("[TB] FAIL drain_count: got %0d expected 16", qa.size()); end
    for (int i = 0; i < 16 && i < qa.size(); i++) begin
      n_checks++;
      if (qa[i] !== exp_beat(f, i)) begin
        n_fail++;
        $display("[TB] FAIL drain_beat%0d: got %h expected %h", i, qa[i], exp_beat(f, i));
      end
    end
    qa.delete();
    gen_frame();
    n_checks++;
    if (qa.size() !== 32) begin n_fail++; $display("[TB] FAIL resync_count: got %0d expected 32", qa.size()); end
    for (int i = 0; i < 32 && i < qa.size(); i++) begin
      n_checks++;
      if (qa[i] !== exp_beat(fid, i)) begin
        n_fail++;
        $display("[TB] FAIL resync_beat%0d: got %h expected %h", i, qa[i], exp_beat(fid, i));
      end
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_checks += 2;
    if (overflow_a !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear: got %0b expected 0", overflow_a); end
    if (size_err_a !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_size_err: got %0b expected 0", size_err_a); end
  endtask

  task automatic test_size_err();
    gen_vs();
    gen_line(0, 8, 4);
    gen_line(1, 8, 4);
    for (int px = 0; px < 7; px++) begin
      vid_de = 1'b1;
      {vid_r, vid_g, vid_b} = pix(fid, 2, px);
      step();
    end
    n_checks++;
    if (size_err_a !== 1'b0) begin n_fail++; $display("[TB] FAIL size_before_eol: got %0b expected 0", size_err_a); end
    vid_de  = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_checks++;
    if (size_err_a !== 1'b1) begin n_fail++; $display("[TB] FAIL size_set_wins: got %0b expected 1", size_err_a); end
    step();
    n_checks++;
    if (size_err_a !== 1'b1) begin n_fail++; $display("[TB] FAIL size_sticky: got %0b expected 1", size_err_a); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_checks++;
    if (size_err_a !== 1'b0) begin n_fail++; $display("[TB] FAIL size_clear: got %0b expected 0", size_err_a); end
    idle(2);
    gen_line(3, 8, 4);
    idle(4);
  endtask

  task automatic test_async_reset();
    m_ready_a = 1'b0;
    gen_vs();
    for (int px = 0; px < 6; px++) begin
      vid_de = 1'b1;
      {vid_r, vid_g, vid_b} = pix(fid, 0, px);
      step();
    end
    n_checks++;
    if (fifo_level_a !== 5'd5) begin n_fail++; $display("[TB] FAIL ar_queued: got %0d expected 5", fifo_level_a); end
    #1 rst_n = 1'b0;
    #1;
    n_checks += 7;
    if (m_valid_a !== 1'b0)    begin n_fail++; $display("[TB] FAIL ar_valid: got %0b expected 0", m_valid_a); end
    if (m_data_a !== 24'd0)    begin n_fail++; $display("[TB] FAIL ar_data: got %h expected 0", m_data_a); end
    if (m_sof_a !== 1'b0)      begin n_fail++; $display("[TB] FAIL ar_sof: got %0b expected 0", m_sof_a); end
    if (m_eol_a !== 1'b0)      begin n_fail++; $display("[TB] FAIL ar_eol: got %0b expected 0", m_eol_a); end
    if (fifo_level_a !== 5'd0) begin n_fail++; $display("[TB] FAIL ar_level: got %0d expected 0", fifo_level_a); end
    if (overflow_a !== 1'b0)   begin n_fail++; $display("[TB] FAIL ar_overflow: got %0b expected 0", overflow_a); end
    if (size_err_a !== 1'b0)   begin n_fail++; $display("[TB] FAIL ar_size_err: got %0b expected 0", size_err_a); end
    step();
    rst_n     = 1'b1;
    m_ready_a = 1'b1;
    qa.delete();
    for (int px = 6; px < 8; px++) begin
      vid_de = 1'b1;
      {vid_r, vid_g, vid_b} = pix(fid, 0, px);
      step();
    end
    idle(4);
    for (int ln = 1; ln < 4; ln++) gen_line(ln, 8, 4);
    idle(4);
    n_checks += 2;
    if (qa.size() !== 0)       begin n_fail++; $display("[TB] FAIL ar_no_beats: got %0d expected 0", qa.size()); end
    if (fifo_level_a !== 5'd0) begin n_fail++; $display("[TB] FAIL ar_idle_level: got %0d expected 0", fifo_level_a); end
    gen_frame();
    n_checks++;
    if (qa.size() !== 32) begin n_fail++; $display("[TB] FAIL ar_resume_count: got %0d expected 32", qa.size()); end
    for (int i = 0; i < 32 && i < qa.size(); i++) begin
      n_checks++;
      if (qa[i] !== exp_beat(fid, i)) begin
        n_fail++;
        $display("[TB] FAIL ar_beat%0d: got %h expected %h", i, qa[i], exp_beat(fid, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    qb.delete();
    f0      = fid + 1;
    stab_en = 1'b1;
    rand_en = 1'b1;
    for (int k = 0; k < 3; k++) gen_frame();
    idle(200);
    rand_en   = 1'b0;
    m_ready_b = 1'b1;
    idle(5);
    stab_en = 1'b0;
    n_checks++;
    if (qb.size() !== 96) begin n_fail++; $display("[TB] FAIL rand_count: got %0d expected 96", qb.size()); end
    for (int i = 0; i < 96 && i < qb.size(); i++) begin
      n_checks++;
      if (qb[i] !== exp_beat(f0 + i / 32, i % 32)) begin
        n_fail++;
        $display("[TB] FAIL rand_beat%0d: got %h expected %h", i, qb[i], exp_beat(f0 + i / 32, i % 32));
      end
    end
    n_checks += 2;
    if (overflow_b !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_overflow: got %0b expected 0", overflow_b); end
    if (size_err_b !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_size_err: got %0b expected 0", size_err_b); end
  endtask

  // Run the scenarios in order; each leaves the stream idle for the next one.
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    fid       = 0;
    rand_en   = 1'b0;
    stab_en   = 1'b0;
    stall_b   = 1'b0;
    held_b    = 26'd0;
    vid_vs    = 1'b0;
    vid_de    = 1'b0;
    vid_r     = 8'd0;
    vid_g     = 8'd0;
    vid_b     = 8'd0;
    clr_err   = 1'b0;
    m_ready_a = 1'b1;
    m_ready_b = 1'b1;
    test_reset();
    test_midframe_release();
    test_full_frame();
    test_overflow();
    test_size_err();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
